// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered bitwise gate with skid-buffered valid/ready handshake
// Optional XOR/XNOR opcodes enabled by defining LOGIC_GATE_UNIT_XOR_EN.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_or_y;
    logic             r_or_err;
    logic             r_or_valid;
    logic [WIDTH-1:0] r_sk_y;
    logic             r_sk_err;
    logic             r_sk_valid;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_res_y;
    logic             w_res_err;
    logic             w_accept;
    logic             w_drain;
    logic             w_or_free;

    always_comb begin
        w_res_y   = '0;
        w_res_err = 1'b0;
        case (op)
            3'd0: w_res_y = a & b;
            3'd1: w_res_y = a | b;
            3'd2: w_res_y = ~(a & b);
            3'd3: w_res_y = ~(a | b);
`ifdef LOGIC_GATE_UNIT_XOR_EN
            3'd4: w_res_y = a ^ b;
            3'd5: w_res_y = ~(a ^ b);
`endif
            default: begin
                w_res_y   = '0;
                w_res_err = 1'b1;
            end
        endcase
    end

    // in_ready is purely registered state, so out_ready never reaches it combinationally.
    assign w_accept  = in_valid && !r_sk_valid;
    assign w_drain   = r_or_valid && out_ready;
    assign w_or_free = w_drain || !r_or_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_or_y     <= '0;
            r_or_err   <= 1'b0;
            r_or_valid <= 1'b0;
            r_sk_y     <= '0;
            r_sk_err   <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (w_or_free) begin
            if (r_sk_valid) begin
                r_or_y     <= r_sk_y;
                r_or_err   <= r_sk_err;
                r_or_valid <= 1'b1;
                r_sk_valid <= 1'b0;
            end else if (w_accept) begin
                r_or_y     <= w_res_y;
                r_or_err   <= w_res_err;
                r_or_valid <= 1'b1;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_sk_y     <= w_res_y;
            r_sk_err   <= w_res_err;
            r_sk_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_drain && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign in_ready  = !r_sk_valid;
    assign out_valid = r_or_valid;
    assign y         = r_or_y;
    assign err       = r_or_err;
    assign count     = r_count;

endmodule
